// File: rtl/zapper_pkg.sv
// rtl/zapper_pkg.sv - shared types and constants for the zapper flash controller
package zapper_pkg;

  // Shot sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_BLACK    = 3'd2,
    ST_TARGET   = 3'd3,
    ST_RESULT   = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  // Player indices
  localparam int P1 = 0;
  localparam int P2 = 1;

  // Bit positions inside the zapper status vector
  localparam int DET1  = 0;
  localparam int TRIG1 = 1;
  localparam int DET2  = 2;
  localparam int TRIG2 = 3;

  // Counter width able to hold values 0..max_val
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/zapper_flash_ctrl_if.sv
// rtl/zapper_flash_ctrl_if.sv - zapper / video / game-logic signal bundle
interface zapper_flash_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic [3:0]         hit;
  logic               frame_start;
  logic               round_reload;
  logic               flash_black;
  logic               flash_target;
  logic               active_player;
  logic               busy;
  logic [1:0]         hit_pulse;
  logic [1:0]         miss_pulse;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0]         shots_p1;
  logic [1:0]         shots_p2;

  // Environment side: supplies zapper status and frame timing, observes results
  modport master (
    output hit, frame_start, round_reload,
    input  flash_black, flash_target, active_player, busy,
    input  hit_pulse, miss_pulse, score_p1, score_p2, shots_p1, shots_p2
  );

  // Controller side
  modport slave (
    input  hit, frame_start, round_reload,
    output flash_black, flash_target, active_player, busy,
    output hit_pulse, miss_pulse, score_p1, score_p2, shots_p1, shots_p2
  );
endinterface

// File: rtl/zapper_edge_detect.sv
// rtl/zapper_edge_detect.sv - single register stage plus rising-edge pulses
module zapper_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] din_q;

  // Keep last cycle's vector so a level held high yields only one pulse
  always_ff @(posedge clk) begin
    if (reset) din_q <= '0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/zapper_flash_ctrl.sv
// rtl/zapper_flash_ctrl.sv - light-gun flash sequencer, hit judge and scorekeeper
module zapper_flash_ctrl
  import zapper_pkg::*;
#(
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 2,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int SHOTS_PER_ROUND = 3,
  parameter int SCORE_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  zapper_flash_ctrl_if.slave  bus
);

  localparam int MAX_FRAMES_BT = (BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES;
  localparam int MAX_FRAMES    = (MAX_FRAMES_BT > COOLDOWN_FRAMES) ? MAX_FRAMES_BT : COOLDOWN_FRAMES;
  localparam int CNT_W         = cnt_width(MAX_FRAMES);
  localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_ROUND);

  state_t             state;
  state_t             next_state;
  logic [3:0]         rise;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               player;
  logic               hit_seen;
  logic               cheat;
  logic [1:0]         shots1;
  logic [1:0]         shots2;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               flash_black_q;
  logic               flash_target_q;
  logic               accept1;
  logic               accept2;
  logic               det_active;
  logic               judged_hit;
  logic               busy;
  logic [1:0]         hit_pulse;
  logic [1:0]         miss_pulse;

  zapper_edge_detect #(.W(4)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.hit),
    .rise  (rise)
  );

  // P1 has priority; an empty budget makes a trigger invisible
  assign accept1    = (state == ST_IDLE) && rise[TRIG1] && (shots1 != 2'd0);
  assign accept2    = (state == ST_IDLE) && rise[TRIG2] && (shots2 != 2'd0) && !accept1;
  assign det_active = player ? rise[DET2] : rise[DET1];
  assign cnt_inc    = frame_cnt + CNT_W'(1);
  assign judged_hit = hit_seen && !cheat;

  // Next-state and combinational outputs
  always_comb begin
    next_state = state;
    busy       = (state != ST_IDLE);
    hit_pulse  = 2'b00;
    miss_pulse = 2'b00;
    case (state)
      ST_IDLE: begin
        if (accept1 || accept2) next_state = ST_ARM;
      end
      ST_ARM: begin
        if (bus.frame_start) next_state = ST_BLACK;
      end
      ST_BLACK: begin
        if (bus.frame_start && (cnt_inc == CNT_W'(BLACK_FRAMES))) next_state = ST_TARGET;
      end
      ST_TARGET: begin
        if (bus.frame_start && (cnt_inc == CNT_W'(TARGET_FRAMES))) next_state = ST_RESULT;
      end
      ST_RESULT: begin
        if (judged_hit) hit_pulse  = player ? 2'b10 : 2'b01;
        else            miss_pulse = player ? 2'b10 : 2'b01;
        next_state = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (bus.frame_start && (cnt_inc == CNT_W'(COOLDOWN_FRAMES))) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Frame counter: cleared on every state change, counts frame_start within a phase
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (next_state != state) begin
      frame_cnt <= '0;
    end else if (bus.frame_start &&
                 (state == ST_BLACK || state == ST_TARGET || state == ST_COOLDOWN)) begin
      frame_cnt <= cnt_inc;
    end
  end

  // Per-shot context: who fired and what the sensor saw during the flash
  always_ff @(posedge clk) begin
    if (reset) begin
      player   <= 1'b0;
      hit_seen <= 1'b0;
      cheat    <= 1'b0;
    end else if (accept1 || accept2) begin
      player   <= accept1 ? 1'(P1) : 1'(P2);
      hit_seen <= 1'b0;
      cheat    <= 1'b0;
    end else if (state == ST_BLACK && det_active) begin
      cheat    <= 1'b1;
    end else if (state == ST_TARGET && det_active) begin
      hit_seen <= 1'b1;
    end
  end

  // Shot budgets: reload overrides a same-cycle decrement
  always_ff @(posedge clk) begin
    if (reset || bus.round_reload) begin
      shots1 <= SHOTS_INIT;
      shots2 <= SHOTS_INIT;
    end else begin
      if (accept1) shots1 <= shots1 - 2'd1;
      if (accept2) shots2 <= shots2 - 2'd1;
    end
  end

  // Saturating scores, bumped when the result cycle judges a hit
  always_ff @(posedge clk) begin
    if (reset) begin
      score1 <= '0;
      score2 <= '0;
    end else if (state == ST_RESULT && judged_hit) begin
      if (!player && (score1 != '1)) score1 <= score1 + SCORE_W'(1);
      if ( player && (score2 != '1)) score2 <= score2 + SCORE_W'(1);
    end
  end

  // Registered flash controls follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_black_q  <= 1'b0;
      flash_target_q <= 1'b0;
    end else begin
      flash_black_q  <= (next_state == ST_BLACK) || (next_state == ST_TARGET);
      flash_target_q <= (next_state == ST_TARGET);
    end
  end

  assign bus.flash_black   = flash_black_q;
  assign bus.flash_target  = flash_target_q;
  assign bus.active_player = player;
  assign bus.busy          = busy;
  assign bus.hit_pulse     = hit_pulse;
  assign bus.miss_pulse    = miss_pulse;
  assign bus.score_p1      = score1;
  assign bus.score_p2      = score2;
  assign bus.shots_p1      = shots1;
  assign bus.shots_p2      = shots2;

endmodule

// File: tb/tb_zapper_flash_ctrl.sv
// tb/tb_zapper_flash_ctrl.sv - self-checking bench for zapper_flash_ctrl
module tb_zapper_flash_ctrl;

  localparam int B = 1;
  localparam int T = 2;
  localparam int C = 4;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hit = 4'b0;
  logic       frame_start = 1'b0;
  logic       round_reload = 1'b0;
  int         frame_len = 20;

  int tests = 0;
  int fails = 0;

  zapper_flash_ctrl_if #(.SCORE_W(8)) ia ();
  zapper_flash_ctrl_if #(.SCORE_W(2)) ib ();

  assign ia.hit = hit;
  assign ia.frame_start = frame_start;
  assign ia.round_reload = round_reload;
  assign ib.hit = hit;
  assign ib.frame_start = frame_start;
  assign ib.round_reload = round_reload;

  zapper_flash_ctrl #(.SCORE_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  zapper_flash_ctrl #(.SCORE_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Free-running vsync generator
  initial begin
    forever begin
      repeat (frame_len - 1) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  end

  // Reference model: a shot is a timeline of frame_starts counted since acceptance
  bit   m_busy, m_in_cd, m_result, m_hit, m_cheat;
  int   m_player, m_n, m_cd;
  int   m_shots[2];
  int   m_score[2];
  logic [3:0] m_prev, r;
  bit   det;
  int   black_only, target_cyc;
  int   hit_cnt[2], miss_cnt[2];
  int   e_fb, e_ft, e_hp, e_mp;

  always @(posedge clk) begin
    r = hit & ~m_prev;
    m_prev = hit;
    if (reset) begin
      m_prev = 4'b0;
      m_busy = 0; m_in_cd = 0; m_result = 0; m_hit = 0; m_cheat = 0;
      m_player = 0; m_n = 0; m_cd = 0;
      m_shots[0] = S; m_shots[1] = S;
      m_score[0] = 0; m_score[1] = 0;
    end else begin
      if (!m_busy) begin
        if (r[1] && m_shots[0] > 0) begin
          m_busy = 1; m_player = 0; m_shots[0]--; m_n = 0;
          m_hit = 0; m_cheat = 0; m_in_cd = 0;
        end else if (r[3] && m_shots[1] > 0) begin
          m_busy = 1; m_player = 1; m_shots[1]--; m_n = 0;
          m_hit = 0; m_cheat = 0; m_in_cd = 0;
        end
      end else if (m_in_cd) begin
        if (frame_start) begin
          m_cd++;
          if (m_cd == C) begin m_busy = 0; m_in_cd = 0; end
        end
      end else if (m_result) begin
        if (m_hit && !m_cheat && m_score[m_player] < 255) m_score[m_player]++;
        m_result = 0; m_in_cd = 1; m_cd = 0;
      end else begin
        det = (m_player == 1) ? r[2] : r[0];
        if (det && m_n >= 1 && m_n <= B) m_cheat = 1;
        if (det && m_n > B && m_n <= B + T) m_hit = 1;
        if (frame_start) begin
          m_n++;
          if (m_n == 1 + B + T) m_result = 1;
        end
      end
      if (round_reload) begin m_shots[0] = S; m_shots[1] = S; end
    end

    #1;
    e_fb = (m_busy && !m_in_cd && !m_result && m_n >= 1 && m_n <= B + T) ? 1 : 0;
    e_ft = (m_busy && !m_in_cd && !m_result && m_n > B && m_n <= B + T) ? 1 : 0;
    e_hp = (m_result && m_hit && !m_cheat) ? (1 << m_player) : 0;
    e_mp = (m_result && !(m_hit && !m_cheat)) ? (1 << m_player) : 0;
    chk("busy", ia.busy, m_busy);
    chk("flash_black", ia.flash_black, e_fb);
    chk("flash_target", ia.flash_target, e_ft);
    chk("hit_pulse", ia.hit_pulse, e_hp);
    chk("miss_pulse", ia.miss_pulse, e_mp);
    chk("score_p1", ia.score_p1, m_score[0]);
    chk("score_p2", ia.score_p2, m_score[1]);
    chk("shots_p1", ia.shots_p1, m_shots[0]);
    chk("shots_p2", ia.shots_p2, m_shots[1]);
    chk("w2_score_p1", ib.score_p1, (m_score[0] > 3) ? 3 : m_score[0]);
    chk("w2_score_p2", ib.score_p2, (m_score[1] > 3) ? 3 : m_score[1]);
    chk("w2_hit_pulse", ib.hit_pulse, e_hp);
    if (m_busy) chk("active_player", ia.active_player, m_player);

    if (ia.flash_black && !ia.flash_target) black_only++;
    if (ia.flash_target) target_cyc++;
    hit_cnt[0] += ia.hit_pulse[0];
    hit_cnt[1] += ia.hit_pulse[1];
    miss_cnt[0] += ia.miss_pulse[0];
    miss_cnt[1] += ia.miss_pulse[1];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    black_only = 0; target_cyc = 0;
    hit_cnt[0] = 0; hit_cnt[1] = 0; miss_cnt[0] = 0; miss_cnt[1] = 0;
  endtask

  task automatic pulse_hit(input int b);
    hit[b] = 1'b1;
    tick(2);
    hit[b] = 1'b0;
    tick(1);
  endtask

  task automatic do_reload();
    round_reload = 1'b1;
    tick(1);
    round_reload = 1'b0;
  endtask

  // 0: idle, 1: busy, 2: target flash, 3: black-only flash
  task automatic wait_for(input int which);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      case (which)
        0: ok = !ia.busy;
        1: ok = ia.busy;
        2: ok = ia.flash_target;
        default: ok = ia.flash_black && !ia.flash_target;
      endcase
      if (!ok) tick(1);
    end
    if (!ok) chk("wait_timeout", which, -1);
  endtask

  task automatic p1_hit_shot();
    pulse_hit(1);
    wait_for(2);
    tick(3);
    pulse_hit(0);
    wait_for(0);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_busy", ia.busy, 0);
    chk("rst_shots_p1", ia.shots_p1, 3);
    chk("rst_score_p1", ia.score_p1, 0);

    // P1 hit
    clear_counts();
    p1_hit_shot();
    chk("t1_score_p1", ia.score_p1, 1);
    chk("t1_shots_p1", ia.shots_p1, 2);
    chk("t1_hits", hit_cnt[0], 1);
    chk("t1_black_len", black_only, frame_len);
    chk("t1_target_len", target_cyc, 2 * frame_len);

    // Cheat by P2: light during black frame
    clear_counts();
    pulse_hit(3);
    wait_for(3);
    pulse_hit(2);
    wait_for(2);
    tick(2);
    pulse_hit(2);
    wait_for(0);
    chk("t2_miss_p2", miss_cnt[1], 1);
    chk("t2_hit_p2", hit_cnt[1], 0);
    chk("t2_score_p2", ia.score_p2, 0);
    chk("t2_shots_p2", ia.shots_p2, 2);

    // Simultaneous triggers: P1 wins
    do_reload();
    tick(1);
    hit[1] = 1'b1; hit[3] = 1'b1;
    tick(2);
    chk("t3_player", ia.active_player, 0);
    chk("t3_shots_p1", ia.shots_p1, 2);
    chk("t3_shots_p2", ia.shots_p2, 3);
    hit[1] = 1'b0; hit[3] = 1'b0;
    wait_for(3);
    pulse_hit(3);
    wait_for(0);
    tick(3);
    chk("t3_shots_p2_after", ia.shots_p2, 3);
    chk("t3_idle_after", ia.busy, 0);

    // Budget exhausted, then reload
    do_reload();
    for (int i = 0; i < 3; i++) begin
      pulse_hit(1);
      wait_for(0);
    end
    chk("t4_shots_empty", ia.shots_p1, 0);
    pulse_hit(1);
    tick(2);
    chk("t4_ignored_busy", ia.busy, 0);
    chk("t4_ignored_flash", ia.flash_black, 0);
    do_reload();
    chk("t4_reloaded", ia.shots_p1, 3);
    pulse_hit(1);
    chk("t4_accepted", ia.busy, 1);
    wait_for(0);

    // Saturation on the narrow-score instance
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      do_reload();
      p1_hit_shot();
      if (i == 2) chk("t5_sat3", ib.score_p1, 3);
    end
    chk("t5_sat4", ib.score_p1, 3);
    chk("t5_wide_score", ia.score_p1, 4);
    chk("t5_hit_pulses", hit_cnt[0], 4);

    // Reset during TARGET
    pulse_hit(3);
    wait_for(2);
    tick(5);
    clear_counts();
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("t6_busy", ia.busy, 0);
    tick(1);
    chk("t6_flash_target", ia.flash_target, 0);
    chk("t6_shots_p2", ia.shots_p2, 3);
    chk("t6_score_p1", ia.score_p1, 0);
    tick(4 * frame_len);
    chk("t6_no_pulses", hit_cnt[0] + hit_cnt[1] + miss_cnt[0] + miss_cnt[1], 0);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) frame_len = $urandom_range(6, 24);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) hit[b] = ~hit[b];
      round_reload = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 1999) == 0);
      tick(1);
    end
    round_reload = 1'b0;
    reset = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zapper_flash_ctrl.md
Name: zapper_flash_ctrl

Overview:
Responder side of the light-gun interface. It consumes the 4-bit zapper status vector (detect/trigger per gun), sequences the frame-synchronous screen flash that makes detection possible (black frames, then white target frames), and judges each shot as a hit or a miss. It keeps per-player scores and shot budgets and sits between the zapper block and the video/game-logic blocks.

Parameters:
BLACK_FRAMES, 1, number of full frames with flash_black asserted
TARGET_FRAMES, 2, number of full frames with flash_target asserted
COOLDOWN_FRAMES, 4, idle frames after a result before a new trigger is accepted
SHOTS_PER_ROUND, 3, shots loaded per player on reset or round_reload
SCORE_W, 8, width of each score counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
hit  in  4  zapper vector: [0] detect1, [1] trigger1 active, [2] detect2, [3] trigger2 active
frame_start  in  1  one-cycle pulse at the start of each video frame (vsync)
round_reload  in  1  one-cycle pulse: reload both shot budgets to SHOTS_PER_ROUND
flash_black  out  1  video blanks the background to black
flash_target  out  1  video draws a white box at the duck position
active_player  out  1  0 = P1, 1 = P2; valid while busy
busy  out  1  high in every state except IDLE
hit_pulse  out  2  one-cycle pulse per player on a judged hit
miss_pulse  out  2  one-cycle pulse per player on a judged miss
score_p1  out  SCORE_W  P1 hits, saturating
score_p2  out  SCORE_W  P2 hits, saturating
shots_p1  out  2  P1 shots remaining
shots_p2  out  2  P2 shots remaining

Behaviour:
- Reset values: all outputs 0, except shots_p1 = shots_p2 = SHOTS_PER_ROUND. State goes to IDLE. Edge registers are cleared.
- hit is registered once. Rising edges of hit[1], hit[3], hit[0] and hit[2] are derived from that registered copy.
- FSM states: IDLE, ARM, BLACK, TARGET, RESULT, COOLDOWN.
- IDLE: a rising edge on trig1 with shots_p1 > 0 latches player 0. A rising edge on trig2 with shots_p2 > 0 latches player 1.
  - Both edges in the same cycle: P1 wins and P2's edge is dropped.
  - A trigger edge with zero shots left is ignored.
  - On acceptance, the player's shots decrement, hit_seen and cheat clear, and the FSM goes to ARM on the next cycle.
- Triggers arriving in any non-IDLE state are ignored and not queued.
- ARM: wait for frame_start, then go to BLACK with the frame counter set to 0.
- BLACK: flash_black = 1. The frame counter increments on each frame_start. At count = BLACK_FRAMES, the FSM goes to TARGET and the counter resets.
  - A rising detect edge for the active player in BLACK sets cheat. The sensor saw light on a black screen.
- TARGET: flash_target = 1 and flash_black = 1. A rising detect edge for the active player sets hit_seen. At count = TARGET_FRAMES, go to RESULT.
- RESULT: lasts exactly one cycle.
  - hit_seen && !cheat: pulse hit_pulse[player]; that player's score increments, saturating at 2^SCORE_W-1.
  - Otherwise: pulse miss_pulse[player].
  - Next state is COOLDOWN.
- COOLDOWN: outputs flash low. After COOLDOWN_FRAMES frame_starts, go to IDLE.
- Detect edges from the non-active player are ignored at all times.
- Flash outputs are registered. They change in the cycle after the frame_start that triggers the transition, so latency from frame_start to the flash change is 1 cycle.
- round_reload: reloads both shot counts in any state. It does not abort the current shot and does not touch scores.
  - If round_reload coincides with a trigger acceptance, the reload wins: the budget equals SHOTS_PER_ROUND, not minus 1.
- A frame_start coinciding with the ARM entry cycle is not counted. ARM waits for the next frame_start.
- Reset mid-sequence: immediate return to IDLE, flashes drop the following cycle, no result pulse is issued.

Decomposition:
- zapper_pkg holds:
  - the state enum;
  - the player index constants P1 = 0 and P2 = 1;
  - named hit-bit indices DET1 = 0, TRIG1 = 1, DET2 = 2, TRIG2 = 3.
- One sub-module, zapper_edge_detect: registers the 4-bit vector and outputs 4 rising-edge pulses, with synchronous reset.
- The FSM, frame counter and scoring stay in zapper_flash_ctrl.

Test Plan:
1. P1 hit: after reset, pulse hit[1]; detect1 rises in the 1st TARGET frame -> flash_black for 1 frame, then flash_target for 2 frames; hit_pulse = 2'b01 for one cycle; score_p1 = 1; shots_p1 = 2.
2. Cheat: P2 fires; hit[2] rises during BLACK and again during TARGET -> miss_pulse = 2'b10; score_p2 = 0; shots_p2 = 2.
3. Simultaneous triggers: hit[1] and hit[3] rise in the same cycle -> active_player = 0; shots_p1 = 2 and shots_p2 = 3. A later trig2 edge during BLACK produces no second sequence.
4. Budget exhausted: 3 P1 shots, then a 4th trigger -> busy stays 0 and no flash. round_reload -> shots_p1 = 3 and the next trigger is accepted.
5. Saturation: with SCORE_W = 2, four P1 hits with reloads between -> score_p1 = 3 after the 3rd and 4th hits; hit_pulse still fires on the 4th.
6. Reset during TARGET -> the next cycle shows the FSM in IDLE; one cycle later flash_target = 0, busy = 0, no hit/miss pulse, scores = 0, shots = 3.
